// File: rtl/weight_loader_if.sv
// Bus bundle for the weight loader: command descriptor, word stream,
// weight-buffer write port and status toward the control block.
// The loader itself uses the slave view; its environment uses the master view.
interface weight_loader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 15,
   parameter int LEN_WIDTH  = 16
);
   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic [ADDR_WIDTH-1:0] cmd_base_i;
   logic [LEN_WIDTH-1:0]  cmd_len_i;
   logic                  abort_i;
   logic                  s_valid_i;
   logic                  s_ready_o;
   logic [DATA_WIDTH-1:0] s_data_i;
   logic                  wb_wr_en_o;
   logic [ADDR_WIDTH-1:0] wb_wr_addr_o;
   logic [DATA_WIDTH-1:0] wb_wr_data_o;
   logic                  wb_wr_ready_i;
   logic                  busy_o;
   logic                  done_o;
   logic                  err_o;
   logic [LEN_WIDTH-1:0]  words_written_o;

   modport slave (
      input  cmd_valid_i, cmd_base_i, cmd_len_i, abort_i,
      input  s_valid_i, s_data_i, wb_wr_ready_i,
      output cmd_ready_o, s_ready_o,
      output wb_wr_en_o, wb_wr_addr_o, wb_wr_data_o,
      output busy_o, done_o, err_o, words_written_o
   );

   modport master (
      output cmd_valid_i, cmd_base_i, cmd_len_i, abort_i,
      output s_valid_i, s_data_i, wb_wr_ready_i,
      input  cmd_ready_o, s_ready_o,
      input  wb_wr_en_o, wb_wr_addr_o, wb_wr_data_o,
      input  busy_o, done_o, err_o, words_written_o
   );
endinterface

// File: rtl/weight_loader.sv
// weight_loader: takes a (base, length) descriptor, streams that many 32-bit
// beats into consecutive weight-buffer addresses, counts the buffer's write
// acks and reports busy/done/error. Descriptors that would run past the end of
// the buffer are rejected without writing anything.
module weight_loader #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 15,
   parameter int DEPTH       = 32768,
   parameter int LEN_WIDTH   = 16,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   weight_loader_if.slave bus
);
   // base+len must be formed one bit wider than either operand so it cannot wrap.
   localparam int SUM_W = ((LEN_WIDTH > ADDR_WIDTH) ? LEN_WIDTH : ADDR_WIDTH) + 1;
   localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_issued;
   logic [LEN_WIDTH-1:0]  r_acked;
   logic [TO_W-1:0]       r_timeout;
   logic                  r_cmd_ready;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;
   logic                  r_wr_en;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;

   logic                  w_cmd_hs;
   logic                  w_s_ready;
   logic                  w_beat;
   logic                  w_ack;
   logic                  w_range_err;
   logic                  w_last_beat;
   logic                  w_acks_complete;
   logic                  w_timeout_hit;
   logic [SUM_W-1:0]      w_range_sum;
   logic [ADDR_WIDTH-1:0] w_beat_addr;
   logic [LEN_WIDTH-1:0]  w_acked_nxt;

   // Handshake decode, range check and next-beat address; acks arriving this cycle count toward completion.
   always_comb begin
      w_cmd_hs = bus.cmd_valid_i & r_cmd_ready;
      if (r_state == ST_STREAM) begin
         w_s_ready = (r_issued < r_len) & ~bus.abort_i;
      end else begin
         w_s_ready = 1'b0;
      end
      w_beat = bus.s_valid_i & w_s_ready;
      w_ack  = bus.wb_wr_ready_i & (r_state != ST_IDLE);
      if (w_ack) begin
         w_acked_nxt = r_acked + LEN_WIDTH'(1'b1);
      end else begin
         w_acked_nxt = r_acked;
      end
      w_range_sum     = SUM_W'(bus.cmd_base_i) + SUM_W'(bus.cmd_len_i);
      w_range_err     = (w_range_sum > SUM_W'(DEPTH));
      w_beat_addr     = r_base + ADDR_WIDTH'(r_issued);
      w_last_beat     = w_beat & ((r_issued + LEN_WIDTH'(1'b1)) == r_len);
      w_acks_complete = (w_acked_nxt >= r_len);
      w_timeout_hit   = (r_timeout == TO_W'(ACK_TIMEOUT - 1));
   end

   // Sequencer FSM together with the registered write port, counters and status outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_IDLE;
         r_base      <= {ADDR_WIDTH{1'b0}};
         r_len       <= {LEN_WIDTH{1'b0}};
         r_issued    <= {LEN_WIDTH{1'b0}};
         r_acked     <= {LEN_WIDTH{1'b0}};
         r_timeout   <= {TO_W{1'b0}};
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= {ADDR_WIDTH{1'b0}};
         r_wr_data   <= {DATA_WIDTH{1'b0}};
      end else begin
         // Write strobe and done are single-cycle unless re-armed below.
         r_wr_en <= w_beat;
         r_done  <= 1'b0;
         if (w_beat) begin
            r_wr_addr <= w_beat_addr;
            r_wr_data <= bus.s_data_i;
            r_issued  <= r_issued + LEN_WIDTH'(1'b1);
         end
         if (w_ack) begin
            r_acked <= w_acked_nxt;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_cmd_hs) begin
                  r_base      <= bus.cmd_base_i;
                  r_len       <= bus.cmd_len_i;
                  r_issued    <= {LEN_WIDTH{1'b0}};
                  r_acked     <= {LEN_WIDTH{1'b0}};
                  r_timeout   <= {TO_W{1'b0}};
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (w_range_err) begin
                     r_err   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else if (bus.cmd_len_i == {LEN_WIDTH{1'b0}}) begin
                     r_err   <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_err   <= 1'b0;
                     r_state <= ST_STREAM;
                  end
               end
            end
            ST_STREAM: begin
               if (bus.abort_i) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else if (w_last_beat) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (bus.abort_i) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else if (w_acks_complete) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else if (w_timeout_hit) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_timeout <= r_timeout + TO_W'(1'b1);
               end
            end
            ST_DONE: begin
               r_busy      <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_busy      <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready_o     = r_cmd_ready;
   assign bus.s_ready_o       = w_s_ready;
   assign bus.wb_wr_en_o      = r_wr_en;
   assign bus.wb_wr_addr_o    = r_wr_addr;
   assign bus.wb_wr_data_o    = r_wr_data;
   assign bus.busy_o          = r_busy;
   assign bus.done_o          = r_done;
   assign bus.err_o           = r_err;
   assign bus.words_written_o = r_acked;
endmodule
